// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core constants and types for the register
//                scoreboard (register address width, register count and
//                default pending-write depth).
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int REG_AW       = 4;
    localparam int NREG         = 16;
    localparam int MAX_PEND_DEF = 3;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/core_arf_sb_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : core_arf_sb_cnt
//  Description : Pending-write counter for one architectural register.
//                Adds one accepted issue and subtracts up to W_PORTS
//                writebacks per cycle. It saturates at zero and flags
//                underflow. A flush clears the count and masks underflow.
//  Revision    : 1.0  initial release
// ============================================================================
module core_arf_sb_cnt #(
    parameter int MAX_PEND = core_pkg::MAX_PEND_DEF,
    parameter int DW       = 2,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_inc,
    input  logic [DW-1:0] i_dec,
    input  logic          i_flush,
    output logic [CW-1:0] o_cnt,
    output logic          o_busy,
    output logic          o_underflow
);

    // Wide enough to hold cnt + inc and the full decrement without wrap
    localparam int c_SW = CW + DW + 1;

    logic [CW-1:0]   r_cnt;
    logic [c_SW-1:0] w_sum;
    logic [c_SW-1:0] w_dec;
    logic            w_under;

    // Next-count arithmetic and underflow detection
    always_comb begin
        w_sum   = c_SW'(r_cnt) + c_SW'(i_inc);
        w_dec   = c_SW'(i_dec);
        w_under = (w_dec > w_sum);
    end

    // Counter register: reset/flush clear it, underflow saturates at zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni || i_flush) begin
            r_cnt <= '0;
        end else if (w_under) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= CW'(w_sum - w_dec);
        end
    end

    assign o_cnt       = r_cnt;
    assign o_busy      = (r_cnt != '0);
    assign o_underflow = w_under & ~i_flush;

endmodule : core_arf_sb_cnt
`default_nettype wire

// File: rtl/core_arf_sb.sv
`default_nettype none
// ============================================================================
//  Module      : core_arf_sb
//  Description : Register scoreboard between decode and the register-file
//                write ports. It counts in-flight writes per register and
//                holds decode on RAW and pending-write overflow hazards.
//                Optional macro CORE_ARF_SB_BYPASS_EN lets this cycle's
//                writebacks clear source hazards in the same cycle, which
//                relies on the forwarding path.
//  Revision    : 1.0  initial release
// ============================================================================
module core_arf_sb #(
    parameter int NREG     = core_pkg::NREG,
    parameter int MAX_PEND = core_pkg::MAX_PEND_DEF,
    parameter int W_PORTS  = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                iss_valid_i,
    input  logic [core_pkg::REG_AW-1:0]         iss_rs_i,
    input  logic [core_pkg::REG_AW-1:0]         iss_rt_i,
    input  logic                                iss_rs_use_i,
    input  logic                                iss_rt_use_i,
    input  logic [core_pkg::REG_AW-1:0]         iss_rd_i,
    input  logic                                iss_rd_we_i,
    output logic                                iss_ready_o,
    input  logic [W_PORTS-1:0]                  wb_en_i,
    input  logic [W_PORTS*core_pkg::REG_AW-1:0] wb_addr_i,
    input  logic                                flush_i,
    output logic [NREG-1:0]                     busy_o,
    output logic                                err_o
);

    import core_pkg::*;

    localparam int c_CW = $clog2(MAX_PEND + 1);
    localparam int c_DW = $clog2(W_PORTS + 1);

    logic [c_DW-1:0] w_dec [NREG];
    logic [c_CW-1:0] w_cnt [NREG];
    logic [NREG-1:0] w_inc;
    logic [NREG-1:0] w_underflow;
    logic [NREG-1:0] w_busy_src;
    logic            w_rs_haz;
    logic            w_rt_haz;
    logic            w_rd_haz;
    logic            w_accept;
    logic            r_err;

    // Count how many writeback ports retire into each register this cycle
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_dec[i] = '0;
            for (int j = 0; j < W_PORTS; j++) begin
                if (wb_en_i[j] && (wb_addr_i[j*REG_AW +: REG_AW] == reg_addr_t'(i))) begin
                    w_dec[i] = w_dec[i] + c_DW'(1);
                end
            end
        end
    end

    // Hazard detection, issue handshake and destination increment decode
    always_comb begin
        w_rs_haz    = iss_rs_use_i & w_busy_src[iss_rs_i];
        w_rt_haz    = iss_rt_use_i & w_busy_src[iss_rt_i];
        w_rd_haz    = iss_rd_we_i & (w_cnt[iss_rd_i] == c_CW'(MAX_PEND));
        iss_ready_o = ~flush_i & rst_ni & ~(w_rs_haz | w_rt_haz | w_rd_haz);
        w_accept    = iss_valid_i & iss_ready_o;
        for (int i = 0; i < NREG; i++) begin
            w_inc[i] = w_accept & iss_rd_we_i & (iss_rd_i == reg_addr_t'(i));
        end
    end

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_cnt
            core_arf_sb_cnt #(
                .MAX_PEND (MAX_PEND),
                .DW       (c_DW),
                .CW       (c_CW)
            ) u_cnt (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .i_inc       (w_inc[g]),
                .i_dec       (w_dec[g]),
                .i_flush     (flush_i),
                .o_cnt       (w_cnt[g]),
                .o_busy      (busy_o[g]),
                .o_underflow (w_underflow[g])
            );

`ifdef CORE_ARF_SB_BYPASS_EN
            // Source is free once this cycle's writebacks cover every pending write
            assign w_busy_src[g] = ((c_CW + c_DW + 1)'(w_cnt[g]) - (c_CW + c_DW + 1)'(w_dec[g])) != '0;
`else
            // Source is free only after the count has registered as zero
            assign w_busy_src[g] = busy_o[g];
`endif
        end
    endgenerate

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (|w_underflow) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule : core_arf_sb
`default_nettype wire
